// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters (x, y) plus one registered stage driving
// RGB, hsync, vsync, data-enable and a frame-start pulse to the VGA DAC.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] h_ext, v_ext;
  logic        active0, hs_win, vs_win;

  assign x       = h_cnt;
  assign y       = v_cnt;
  assign h_ext   = {1'b0, h_cnt};
  assign v_ext   = {1'b0, v_cnt};
  assign active0 = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_win  = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_win  = (v_ext >= VS_BEG) && (v_ext < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Output stage holds through disabled cycles, frame_start included
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
    end else if (pixel_en) begin
      vga_r       <= active0 ? red_in   : 4'd0;
      vga_g       <= active0 ? green_in : 4'd0;
      vga_b       <= active0 ? blue_in  : 4'd0;
      de          <= active0;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      hsync       <= hs_win ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= vs_win ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-raster instance, its inverted-polarity twin and a
// default 640x480 instance run side by side against queued expected outputs.
module tb_vga_timing_gen;
  typedef struct {
    int          x, y;
    logic [11:0] rgb;
    logic        hs, vs, de, fs;   // hs/vs in active-low sense
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pixel_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] xs, ys, xp, yp, xd, yd;
  logic [3:0] rs, gs, bs, rp, gp, bp, rd, gd, bd;
  logic       hss, vss, des, fss, hsp, vsp, dep, fsp, hsd, vsd, ded, fsd;

  // 15x8 raster: hsync window x=10..12, vsync window y=5..6, active 8x4
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
    .clk(clk), .rst(rst), .pixel_en(pixel_en),
    .red_in(xs[3:0]), .green_in(ys[3:0]), .blue_in(4'hA),
    .x(xs), .y(ys), .vga_r(rs), .vga_g(gs), .vga_b(bs),
    .hsync(hss), .vsync(vss), .de(des), .frame_start(fss));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut_p (
    .clk(clk), .rst(rst), .pixel_en(pixel_en),
    .red_in(xp[3:0]), .green_in(yp[3:0]), .blue_in(4'hA),
    .x(xp), .y(yp), .vga_r(rp), .vga_g(gp), .vga_b(bp),
    .hsync(hsp), .vsync(vsp), .de(dep), .frame_start(fsp));

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pixel_en(pixel_en),
    .red_in(xd[3:0]), .green_in(yd[3:0]), .blue_in(4'hA),
    .x(xd), .y(yd), .vga_r(rd), .vga_g(gd), .vga_b(bd),
    .hsync(hsd), .vsync(vsd), .de(ded), .frame_start(fsd));

  int checks = 0;
  int errors = 0;
  exp_t qs[$], qd[$];
  exp_t es, ed;

  task automatic cmp(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // Expected outputs after the next clock edge, given those after the current one
  function automatic exp_t nxt(exp_t p, logic r, logic en,
                               int ha, int hf, int hsw, int hb,
                               int va, int vf, int vsw, int vb);
    exp_t e = p;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    logic act;
    if (r) begin
      e.x = 0; e.y = 0; e.rgb = '0;
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
    end else if (en) begin
      act   = (p.x < ha) && (p.y < va);
      e.rgb = act ? {4'(p.x), 4'(p.y), 4'hA} : 12'h000;
      e.de  = act;
      e.hs  = !(p.x >= ha + hf && p.x < ha + hf + hsw);
      e.vs  = !(p.y >= va + vf && p.y < va + vf + vsw);
      e.fs  = (p.x == 0) && (p.y == 0);
      e.x   = (p.x == ht - 1) ? 0 : p.x + 1;
      e.y   = (p.x != ht - 1) ? p.y : ((p.y == vt - 1) ? 0 : p.y + 1);
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic en);
    @(negedge clk);
    rst = r;
    pixel_en = en;
    es = nxt(es, r, en, 8, 2, 3, 2, 4, 1, 2, 1);
    ed = nxt(ed, r, en, 640, 16, 96, 48, 480, 10, 2, 33);
    qs.push_back(es);
    qd.push_back(ed);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge presents a new output state; compare against the queue
  initial begin
    exp_t s, d;
    forever begin
      @(posedge clk);
      #1;
      if (qs.size() > 0) begin
        s = qs.pop_front();
        d = qd.pop_front();
        cmp("s_x", xs, s.x);      cmp("s_y", ys, s.y);
        cmp("s_rgb", {rs, gs, bs}, s.rgb);
        cmp("s_hs", hss, s.hs);   cmp("s_vs", vss, s.vs);
        cmp("s_de", des, s.de);   cmp("s_fs", fss, s.fs);
        cmp("p_hs", hsp, !s.hs);  cmp("p_vs", vsp, !s.vs);
        cmp("d_x", xd, d.x);      cmp("d_y", yd, d.y);
        cmp("d_rgb", {rd, gd, bd}, d.rgb);
        cmp("d_hs", hsd, d.hs);   cmp("d_vs", vsd, d.vs);
        cmp("d_de", ded, d.de);   cmp("d_fs", fsd, d.fs);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    es = '{x: 0, y: 0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};
    ed = es;
    step(1'b1, 1'b1);
    after_edge();
    cmp("rst_x", xs, 0); cmp("rst_hs", hss, 1); cmp("rst_de", des, 0);
    cmp("rst_p_hs", hsp, 0); cmp("rst_p_vs", vsp, 0);

    // Default raster reaches (5,3) after 2405 enabled cycles
    run(2405);
    step(1'b0, 1'b1);
    after_edge();
    cmp("d_pix53_rgb", {rd, gd, bd}, 12'h53A); cmp("d_pix53_de", ded, 1);
    cmp("d_x_after", xd, 6);
    cmp("s_pix50_rgb", {rs, gs, bs}, 12'h50A);

    // Default (700,3): blanked in hsync; small raster emits (10,6): both syncs on
    run(694);
    step(1'b0, 1'b1);
    after_edge();
    cmp("d_pix700_rgb", {rd, gd, bd}, 12'h000); cmp("d_pix700_de", ded, 0);
    cmp("d_pix700_hs", hsd, 0); cmp("d_pix700_vs", vsd, 1);
    cmp("s_sync_hs", hss, 0); cmp("s_sync_vs", vss, 0);
    cmp("p_sync_hs", hsp, 1); cmp("p_sync_vs", vsp, 1);
    cmp("s_pre_rst_x", xs, 11); cmp("s_pre_rst_y", ys, 6);

    // Reset while both syncs are asserted
    step(1'b1, 1'b1);
    after_edge();
    cmp("mid_rst_xy", {xs, ys}, 0); cmp("mid_rst_hs", hss, 1);
    cmp("mid_rst_vs", vss, 1); cmp("mid_rst_rgb", {rs, gs, bs}, 0);
    step(1'b0, 1'b1);
    after_edge();
    cmp("fs_first", fss, 1); cmp("de_first", des, 1);
    step(1'b0, 1'b0);
    after_edge();
    cmp("fs_hold", fss, 1);
    step(1'b0, 1'b1);
    after_edge();
    cmp("fs_drop", fss, 0);

    for (int i = 0; i < 300; i++) step(1'b0, (i % 2) == 0);

    // Reset mid-line at small-raster (3,2) while hsync is idle
    for (int i = 0; i < 200 && !(es.x == 3 && es.y == 2); i++) step(1'b0, 1'b1);
    after_edge();
    cmp("pre_rst2_xy", {xs, ys}, {10'd3, 10'd2}); cmp("pre_rst2_hs", hss, 1);
    step(1'b1, 1'b0);
    after_edge();
    cmp("rst2_xy", {xs, ys}, 0); cmp("rst2_de", des, 0);

    for (int i = 0; i < 240; i++) step(1'b0, 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #2;
    cmp("queue_drained", qs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives the pixel-pattern stage: produces the current (x, y) scan coordinate, samples the 4-bit-per-channel RGB returned for that coordinate, and drives the registered VGA pins (RGB, hsync, vsync).
- Sits between the pixel pattern/renderer logic and the board VGA DAC.
- Default parameters give 640x480@60 Hz from a 25 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pixel_en  in  1  pixel-rate enable; all state advances only on cycles with pixel_en=1
- red_in  in  4  red for current (x, y), combinational from pattern stage
- green_in  in  4  green for current (x, y)
- blue_in  in  4  blue for current (x, y)
- x  out  10  current horizontal counter value, 0..H_TOTAL-1
- y  out  10  current vertical counter value, 0..V_TOTAL-1
- vga_r  out  4  registered red to DAC
- vga_g  out  4  registered green to DAC
- vga_b  out  4  registered blue to DAC
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered data-enable; 1 while the emitted pixel is visible
- frame_start  out  1  registered one-cycle pulse when pixel (0,0) is emitted

Behaviour:
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both totals must be ≤1024. An elaboration-time check fails otherwise.
- Stage 0 (counters):
  - h_cnt and v_cnt are registers; x = h_cnt and y = v_cnt directly. x and y are not masked during blanking.
  - When pixel_en=1, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 in the same cycle that h_cnt wraps.
  - When pixel_en=0, the counters hold.
- Stage 1 (outputs): all outputs below register only on cycles with pixel_en=1, from the stage-0 values of that cycle. They hold otherwise.
  - active0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - vga_r/g/b <= active0 ? {red_in, green_in, blue_in} : 0.
  - de <= active0.
  - hsync <= H_SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise hsync <= ~H_SYNC_POL.
  - vsync <= V_SYNC_POL when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise vsync <= ~V_SYNC_POL.
  - frame_start <= (h_cnt==0 && v_cnt==0).
- Latency: the pin outputs for coordinate (h, v) appear one enabled cycle after x,y = (h, v). RGB, sync and de are mutually aligned.
- vsync is line-aligned: it changes on the same emitted pixel as the h_cnt=0 boundary. It is not offset to hsync.
- Reset (rst=1 at a clock edge, regardless of pixel_en): h_cnt=v_cnt=0, so x=y=0.
  - Output reset values: vga_r=vga_g=vga_b=0, de=0, frame_start=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL.
  - Reset mid-frame aborts the frame immediately. No partial sync pulse is extended.
- First frame after reset release, with pixel_en=1: in cycle 1, x,y=(0,0); in cycle 2, frame_start=1, de=1, RGB = colour sampled for (0,0).
- pixel_en=0 cycles are invisible to timing. Every output holds its value, including frame_start if it is high.
  - Consequence: downstream logic must qualify frame_start with pixel_en.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1): the next enabled cycle is (0,0). No skipped or duplicated line.

Test Plan:
- Reset, then pixel_en=1 continuously: x counts 0..799 then 0; y increments every 800 cycles; after 420000 cycles x=y=0 again; frame_start pulses exactly once per 420000 cycles.
- Same run: hsync=0 for exactly 96 consecutive cycles per line, starting 1 cycle after x=656; vsync=0 for exactly 1600 cycles per frame, starting 1 cycle after (x=0, y=490); de=1 for 640 cycles per visible line, 307200 per frame.
- Drive red_in=x[3:0], green_in=y[3:0], blue_in=4'hA: at the cycle after x=5,y=3 expect vga_r=5, vga_g=3, vga_b=A, de=1; at the cycle after x=700 expect RGB=0, de=0 although blue_in=A.
- pixel_en alternating 1,0: frame period is 840000 cycles; all outputs stable across each en=0 cycle; the sequence of emitted pixels is identical to the continuous-enable run.
- Assert rst for one cycle at x=300,y=200, while hsync is deasserted mid-line, and separately at x=700,y=490 while hsync and vsync are both asserted: next cycle x=y=0, RGB=0, de=0, hsync=vsync=1; frame_start=1 two enabled cycles after reset release.
- H_SYNC_POL=1, V_SYNC_POL=1: reset values hsync=vsync=0; hsync=1 during the 96-cycle pulse window; vsync=1 for 1600 cycles per frame.
